// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer: FSM states, counter sizing,
// and the default word width that also sizes the downstream 4-bit SIPO.
package piso_pkg;

  // Default word width, matching the downstream SIPO.
  localparam int DEF_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // The bit counter must hold values up to WIDTH (the parity cycle index).
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Loadable WIDTH-bit shift register. A load takes priority over a shift.
// Zeros are shifted in behind the data, so the register drains to all-zero
// once a whole word has gone out. That keeps the output bit at 0 when idle.
module piso_shreg #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             sbit
);

  logic [WIDTH-1:0] sr;

  // Capture a new word on load, otherwise move one bit toward the output end.
  always_ff @(posedge clk) begin
    if (rst)
      sr <= '0;
    else if (load)
      sr <= data;
    else if (shift)
      sr <= LSB_FIRST ? {1'b0, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], 1'b0};
  end

  assign sbit = LSB_FIRST ? sr[0] : sr[WIDTH-1];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage that feeds the 4-bit SIPO, one bit per clk.
// Optional feature macro: PISO_PARITY_EN. When it is defined, an even-parity
// bit follows the data bits and each word occupies WIDTH+1 serial cycles.
// The FSM, bit counter, handshake and parity live here. The data path is
// the piso_shreg instance.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sdout,
  output logic             sdout_valid,
  output logic             word_done
);

`ifdef PISO_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(N - 2);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            last;
  logic            shreg_bit;

  assign accept = load_valid & load_ready;
  assign last   = (state == SHIFT) && (cnt == CNT_LAST);

  piso_shreg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (state == SHIFT),
    .data  (load_data),
    .sbit  (shreg_bit)
  );

  // Control FSM. The framing flags and load_ready are registered from the
  // next-cycle position, so each one lines up with the bit it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      load_ready  <= 1'b1;
      sdout_valid <= 1'b0;
      word_done   <= 1'b0;
    end else if (accept) begin
      // Also covers the zero-gap reload in the final bit cycle.
      state       <= SHIFT;
      cnt         <= '0;
      load_ready  <= 1'b0;
      sdout_valid <= 1'b1;
      word_done   <= 1'b0;
    end else if (state == SHIFT) begin
      if (last) begin
        state       <= IDLE;
        cnt         <= '0;
        load_ready  <= 1'b1;
        sdout_valid <= 1'b0;
        word_done   <= 1'b0;
      end else begin
        cnt         <= cnt + 1'b1;
        load_ready  <= (cnt == CNT_PENULT);
        word_done   <= (cnt == CNT_PENULT);
      end
    end
  end

`ifdef PISO_PARITY_EN
  logic par_bit;
  logic par_phase;

  // Latch the word's parity at accept. Flag the trailing cycle that carries it.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit   <= 1'b0;
      par_phase <= 1'b0;
    end else if (accept) begin
      par_bit   <= ^load_data;
      par_phase <= 1'b0;
    end else if (state == SHIFT) begin
      par_phase <= !last && (cnt == CNT_PENULT);
    end
  end

  assign sdout = sdout_valid & (par_phase ? par_bit : shreg_bit);
`else
  assign sdout = sdout_valid & shreg_bit;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (default: WIDTH=4, LSB first).
// A queue-based reference model checks every cycle. Directed table vectors
// and hand sequences add explicit expected values.
module tb_piso_serializer;
  localparam int W = piso_pkg::DEF_WIDTH;
`ifdef PISO_PARITY_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_ready, sdout, sdout_valid, word_done;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .sdout       (sdout),
    .sdout_valid (sdout_valid),
    .word_done   (word_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: the bits still to be sent, front = the bit on sdout this cycle.
  bit           mq[$];
  logic [W-1:0] sipo = '0;
  logic         s_sdout, s_valid, s_done, s_ready;
  bit           last_acc;

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] exp;  // exp[i] = sdout on serial cycle i+1
    logic         par;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) mq.push_back(d[i]);
`ifdef PISO_PARITY_EN
    mq.push_back(^d);
`endif
  endtask

  // Sample and check at negedge, then advance model and DUT through a posedge.
  task automatic cycle();
    bit er;
    @(negedge clk);
    s_sdout = sdout; s_valid = sdout_valid; s_done = word_done; s_ready = load_ready;
    er = (mq.size() <= 1);
    chk("m_valid", s_valid, mq.size() > 0);
    chk("m_sdout", s_sdout, (mq.size() > 0) ? mq[0] : 1'b0);
    chk("m_done",  s_done,  mq.size() == 1);
    chk("m_ready", s_ready, er);
    last_acc = load_valid && er && !rst;
    @(posedge clk);
    if (rst) mq.delete();
    else begin
      if (mq.size() > 0) void'(mq.pop_front());
      if (last_acc) push_word(load_data);
    end
    if (s_valid) sipo = {s_sdout, sipo[W-1:1]};
    #1;
  endtask

  initial begin
    logic [15:0] bits;
    int nv, first_v, last_v, d1, d2, nd;

    tbl[0] = '{data: 4'b1011, exp: 4'b1011, par: 1'b1};
    tbl[1] = '{data: 4'b0111, exp: 4'b0111, par: 1'b1};
    tbl[2] = '{data: 4'hA,    exp: 4'b1010, par: 1'b0};
    tbl[3] = '{data: 4'h3,    exp: 4'b0011, par: 1'b0};
    tbl[4] = '{data: 4'h8,    exp: 4'b1000, par: 1'b1};

    // Reset held for two cycles.
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    chk("rst_ready", s_ready, 1); chk("rst_sdout", s_sdout, 0);
    chk("rst_valid", s_valid, 0); chk("rst_done", s_done, 0);

    // Single words from the table.
    foreach (tbl[t]) begin
      load_valid = 1'b1; load_data = tbl[t].data;
      cycle();
      load_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
        cycle();
        chk("vec_sdout", s_sdout, (i < W) ? tbl[t].exp[i] : tbl[t].par);
        chk("vec_valid", s_valid, 1);
        chk("vec_done", s_done, i == N - 1);
        if (i == W - 1) chk("vec_sipo", sipo, tbl[t].data);
      end
      cycle();
      chk("vec_idle", s_valid, 0);
    end

    // Back-to-back words: A, then 5 offered immediately and held.
    load_valid = 1'b1; load_data = 4'hA;
    cycle();
    load_data = 4'h5;
    bits = '0; nv = 0; first_v = -1; last_v = -1; d1 = -1; d2 = -1; nd = 0;
    for (int k = 0; k < 2 * N + 2; k++) begin
      cycle();
      if (last_acc) load_valid = 1'b0;
      if (s_valid) begin
        bits[nv] = s_sdout; nv++;
        if (first_v < 0) first_v = k;
        last_v = k;
      end
      if (s_done) begin
        if (nd == 0) d1 = k; else d2 = k;
        nd++;
      end
    end
    chk("b2b_count", nv, 2 * N);
    chk("b2b_contig", last_v - first_v + 1, 2 * N);
`ifdef PISO_PARITY_EN
    chk("b2b_stream", bits, 16'h00AA);
`else
    chk("b2b_stream", bits, 16'h005A);
`endif
    chk("b2b_ndone", nd, 2);
    chk("b2b_gap", d2 - d1, N);

    // Backpressure: the next word is offered during the shift and must wait.
    load_valid = 1'b1; load_data = 4'h6;
    cycle();
    load_data = 4'h9;
    for (int i = 0; i < N; i++) begin
      cycle();
      chk("bp_ready", s_ready, i == N - 1);
      chk("bp_acc", last_acc, i == N - 1);
    end
    load_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      cycle();
      chk("bp_sdout", s_sdout, (i == 0 || i == 3) ? 1 : 0);
    end
    repeat (N - W + 1) cycle();

    // Reset in the middle of a word.
    load_valid = 1'b1; load_data = 4'hF;
    cycle();
    load_valid = 1'b0;
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    chk("mid_nodone", s_done, 0);
    rst = 1'b0;
    cycle();
    chk("mid_sdout", s_sdout, 0); chk("mid_valid", s_valid, 0);
    chk("mid_done", s_done, 0); chk("mid_ready", s_ready, 1);
    load_valid = 1'b1; load_data = 4'h3;
    cycle();
    load_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      cycle();
      chk("mid_next", s_sdout, i < 2);
    end
    repeat (N - W + 1) cycle();

    // Reset and accept at the same edge: the word is dropped.
    load_valid = 1'b1; load_data = 4'hC; rst = 1'b1;
    cycle();
    rst = 1'b0; load_valid = 1'b0;
    cycle();
    chk("rst_acc_drop", s_valid, 0);

    // Random traffic with occasional resets, checked by the model.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!load_valid || last_acc) begin
        load_valid = ($urandom_range(0, 3) != 0);
        load_data  = W'($urandom);
      end
      cycle();
    end
    rst = 1'b0; load_valid = 1'b0;
    repeat (N + 2) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the team's 4-bit serial-in/parallel-out shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and drives it one bit per clk on sdout.
- Sends LSB first, so that after WIDTH shifts the downstream SIPO holds the word unchanged: bit0 ends up in q[0].
- Provides framing flags (sdout_valid, word_done) so the consumer knows when its parallel output is a complete word.

Parameters:
- WIDTH, 4, data word width in bits (legal range ≥2; default matches the downstream 4-bit SIPO).
- LSB_FIRST, 1, 1 = shift bit0 first; 0 = shift bit WIDTH-1 first.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  upstream offers load_data this cycle.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  word to serialize; sampled only on handshake.
- sdout  output  1  serial data bit; connects to the SIPO d input.
- sdout_valid  output  1  sdout carries a real data (or parity) bit this cycle.
- word_done  output  1  one-cycle pulse coinciding with the final bit of a word.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, shift register=0, bit counter=0. Outputs: load_ready=1, sdout=0, sdout_valid=0, word_done=0.
- Reset mid-word aborts the word; no partial word_done is produced.
- The reset value of load_ready follows state after the reset edge, not rst combinationally.
- Handshake: accept occurs at a posedge where load_valid & load_ready. load_data is captured into the shift register; counter cleared.
- load_valid with load_ready=0 is ignored. Upstream must hold the word until accepted.
- State machine:
  - IDLE: load_ready=1, sdout_valid=0, sdout=0. On accept → SHIFT.
  - SHIFT: sdout = current output bit (bit0 when LSB_FIRST=1), sdout_valid=1. Each cycle, shift by one and increment the counter.
  - SHIFT lasts N = WIDTH cycles (WIDTH+1 with parity); the counter runs 0..N-1.
  - On counter = N-1: word_done=1 and load_ready=1.
    - Accept in this cycle → stay in SHIFT with the new word; its first bit appears next cycle, giving zero-gap back-to-back operation.
    - No accept → IDLE.
- Latency: first bit on sdout in the cycle immediately after accept. Last bit appears N cycles after accept.
- load_ready is 0 in SHIFT except in the final bit cycle.
- Counter width = $clog2(WIDTH+1). It never wraps past N-1.
- sdout is registered (driven from the shift register / state) and has no combinational path from load_data.
- Simultaneous rst and accept: rst wins and the word is dropped.

Optional Feature:
- Macro PISO_PARITY_EN.
- Defined: one even-parity bit (XOR of all WIDTH data bits) is appended after the data bit. SHIFT then lasts WIDTH+1 cycles, and word_done pulses on the parity-bit cycle.
- Undefined: no parity logic and N=WIDTH.

Decomposition:
- Package piso_pkg:
  - state enum {IDLE, SHIFT}
  - localparam function for counter width
  - default WIDTH constant shared with the SIPO bench
- One natural sub-module: piso_shreg. It holds a loadable WIDTH-bit shift register with load/shift enables and a direction set by LSB_FIRST. The FSM, counter, handshake and parity live in the top.

Test Plan:
- Reset: hold rst=1 for 2 cycles → load_ready=1, sdout=0, sdout_valid=0, word_done=0.
- Single word: load 4'b1011 in IDLE:
  - sdout = 1,1,0,1 on cycles 1–4 after accept.
  - word_done high only on cycle 4.
  - Downstream SIPO q=4'b1011 after the 4th posedge.
- Back-to-back: load_valid held with 4'hA then 4'h5 → exactly 8 consecutive sdout_valid cycles, serial stream 0,1,0,1,1,0,1,0, and two word_done pulses 4 cycles apart.
- Backpressure: load_valid asserted during SHIFT cycles 1–3 → not accepted until the last bit cycle. The word is held stable and sent next.
- Reset mid-word: rst pulse after 2 bits of 4'hF → sdout=0 and IDLE next cycle, with no word_done. The next load of 4'h3 serializes cleanly.
- PISO_PARITY_EN defined: load 4'b0111 → stream 1,1,1,0 then parity 1. word_done falls on the 5th cycle.
